bit_reverse_buffer: RTL
=======================

Name: bit_reverse_buffer

Overview:
- Sits directly downstream of the UART sample assembler, which delivers one complex sample per en pulse (Re/Im, sign-extended, scaled by 64).
- Collects one N-point frame and stores each sample k at address bitrev(k).
- Streams the frame out in natural address order over a valid/ready handshake into the FFT butterfly stage, so the FFT receives its input already in bit-reversed order.
- While the frame drains, new input is dropped and flagged.

Parameters:
- bit_width, 32: width of Re/Im samples.
- N, 16: frame length in points (power of 2).
- SIZE, 4: log2(N); address and index width.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- en_i  input  1  one-cycle strobe; Re_i/Im_i are valid this cycle.
- Re_i  input  bit_width  signed real part.
- Im_i  input  bit_width  signed imaginary part.
- out_valid_o  output  1  Re_o/Im_o/idx_o/last_o are valid.
- out_ready_i  input  1  downstream accepts; transfer occurs when out_valid_o && out_ready_i.
- Re_o  output  bit_width  signed real part, read from RAM address idx_o.
- Im_o  output  bit_width  signed imaginary part.
- idx_o  output  SIZE  output address j, 0..N-1.
- last_o  output  1  high with idx_o == N-1.
- busy_o  output  1  high in PRIME/DRAIN; input is not accepted.
- overflow_o  output  1  sticky; set when en_i arrives while busy_o is high.

Behaviour:
- Reset (asynchronous, active-low):
  - Outputs: out_valid_o=0, Re_o=0, Im_o=0, idx_o=0, last_o=0, busy_o=0, overflow_o=0.
  - State goes to COLLECT, and the write counter wr_cnt and read counter rd_cnt go to 0.
  - RAM contents are not cleared.
  - A reset mid-frame or mid-drain discards the partial frame. The next en_i after release is sample 0.
- COLLECT:
  - On en_i: write {Re_i, Im_i} to RAM[bitrev(wr_cnt)], then wr_cnt += 1.
  - When the write has wr_cnt == N-1: wr_cnt wraps to 0 and the next state is PRIME.
  - Without en_i: hold.
- PRIME (1 cycle):
  - Issue RAM read of address 0 (synchronous RAM, 1-cycle read latency).
  - Set rd_cnt=0 and busy_o=1. Next state is DRAIN.
- DRAIN:
  - The registered RAM output drives Re_o/Im_o. out_valid_o=1, idx_o=rd_cnt, last_o=(rd_cnt==N-1).
  - On transfer with rd_cnt<N-1: rd_cnt += 1 and read address rd_cnt+1 is issued in the same cycle, so back-to-back transfers give one sample per clock.
  - On transfer with rd_cnt==N-1: next cycle out_valid_o=0, busy_o=0, last_o=0, state returns to COLLECT.
  - With out_valid_o && !out_ready_i: Re_o, Im_o, idx_o and last_o hold stable. The RAM read enable is gated off.
- Latency:
  - en_i of the N-th sample at cycle t.
  - State PRIME at t+1.
  - out_valid_o first high at t+2 with idx_o=0.
  - Minimum drain time is N cycles.
- Input during PRIME/DRAIN:
  - en_i is ignored: no write, wr_cnt unchanged, overflow_o set to 1.
  - overflow_o clears only on reset.
- Simultaneous events: en_i in the same cycle as the final transfer is dropped and flagged, because busy_o is still 1 in that cycle.
- Widths:
  - No arithmetic on data; samples pass bit-exact.
  - bitrev(k) reverses the SIZE LSBs of k.
  - Counters are SIZE+1 bits wide internally; only SIZE bits address the RAM.

Decomposition:
- Shared package fft_pkg holds:
  - default bit_width, N, SIZE constants;
  - function bitrev(k, SIZE);
  - state encoding (one-hot: COLLECT, PRIME, DRAIN).
- One sub-module, fft_sample_ram:
  - simple dual-port, depth N, width 2*bit_width;
  - one write port, one read port with read enable;
  - 1-cycle registered read.

Test Plan:
- Ordering: N=16; feed 16 samples k with Re=k*64, Im=-k*64; out_ready_i=1.
  - Output j carries sample bitrev(j); j=1 gives Re=512, Im=-512.
  - Sequence is idx 0..15, last_o only at idx 15.
  - First out_valid_o occurs 2 cycles after the 16th en_i.
- Backpressure: drop out_ready_i for 5 cycles at idx 3.
  - Re_o, Im_o, idx_o hold at idx 3 (sample 12, Re=768).
  - Drain resumes with no loss or duplicate.
- Overflow: pulse en_i during DRAIN.
  - overflow_o=1 and the frame output is unchanged.
  - The next frame starts at sample 0 after busy_o falls.
- Back-to-back frames: two frames, the second with Re=1000+k.
  - The second drain is correct and overflow_o stays 0.
- Reset mid-frame: assert rst_n=0 after 7 samples.
  - All outputs return to reset values.
  - A full 16-sample frame after release drains correctly with no remnants of the partial frame.
- Sign integrity: samples Re=-2^(bit_width-1) and Re=2^(bit_width-1)-1 are output bit-exact.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, state encoding and the bit-reversal helper for the FFT input path.
package fft_pkg;

    localparam int BIT_WIDTH_DEF = 32;
    localparam int N_DEF         = 16;
    localparam int SIZE_DEF      = 4;

    typedef enum logic [2:0] {
        ST_COLLECT = 3'b001,
        ST_PRIME   = 3'b010,
        ST_DRAIN   = 3'b100
    } state_e;

    // Reverse the low 'size' bits of k; higher bits of k are ignored.
    function automatic logic [31:0] bitrev(input logic [31:0] k, input int size);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[31-i] = k[i];
        end
        return r >> (32 - size);
    endfunction

endpackage

// File: rtl/fft_sample_ram.sv
// Simple dual-port sample RAM: one write port, one read port with enable and a 1-cycle registered read.
module fft_sample_ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the read register is reset so the downstream data outputs start at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bit_reverse_buffer.sv
// Collects one N-point frame into bit-reversed RAM slots, then streams it out in natural
// address order over valid/ready so the FFT sees bit-reversed input order.
module bit_reverse_buffer
    import fft_pkg::*;
#(
    parameter int bit_width = BIT_WIDTH_DEF,
    parameter int N         = N_DEF,
    parameter int SIZE      = SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic [bit_width-1:0] Re_i,
    input  logic [bit_width-1:0] Im_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [bit_width-1:0] Re_o,
    output logic [bit_width-1:0] Im_o,
    output logic [SIZE-1:0]      idx_o,
    output logic                 last_o,
    output logic                 busy_o,
    output logic                 overflow_o
);

    localparam logic [SIZE:0] LAST_CNT = (SIZE+1)'(N - 1);

    state_e                 state_q, state_d;
    logic [SIZE:0]          wr_cnt_q, wr_cnt_d;
    logic [SIZE:0]          rd_cnt_q, rd_cnt_d;
    logic                   overflow_q, overflow_d;
    logic                   fire;
    logic                   wr_en, rd_en;
    logic [SIZE-1:0]        wr_addr, rd_addr;
    logic [2*bit_width-1:0] rd_data;

    assign fire = (state_q == ST_DRAIN) && out_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_COLLECT: if (en_i && wr_cnt_q == LAST_CNT) state_d = ST_PRIME;
            ST_PRIME:   state_d = ST_DRAIN;
            ST_DRAIN:   if (fire && rd_cnt_q == LAST_CNT) state_d = ST_COLLECT;
            default:    state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // The read for the next index is issued on the accepting edge so back-to-back
    // transfers stream one sample per clock; a stalled transfer leaves the read register alone.
    always_comb begin
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        wr_addr    = SIZE'(bitrev(32'(wr_cnt_q[SIZE-1:0]), SIZE));
        case (state_q)
            ST_COLLECT: begin
                if (en_i) begin
                    wr_en    = 1'b1;
                    wr_cnt_d = (wr_cnt_q == LAST_CNT) ? '0 : wr_cnt_q + (SIZE+1)'(1);
                end
            end
            ST_PRIME: begin
                rd_en    = 1'b1;
                rd_addr  = '0;
                rd_cnt_d = '0;
            end
            ST_DRAIN: begin
                if (fire) begin
                    if (rd_cnt_q == LAST_CNT) begin
                        rd_cnt_d = '0;
                    end else begin
                        rd_en    = 1'b1;
                        rd_addr  = rd_cnt_q[SIZE-1:0] + SIZE'(1);
                        rd_cnt_d = rd_cnt_q + (SIZE+1)'(1);
                    end
                end
            end
            default: ;
        endcase
        if (en_i && state_q != ST_COLLECT) begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        busy_o      = (state_q != ST_COLLECT);
        out_valid_o = (state_q == ST_DRAIN);
        last_o      = (state_q == ST_DRAIN) && (rd_cnt_q == LAST_CNT);
        idx_o       = rd_cnt_q[SIZE-1:0];
        Re_o        = rd_data[2*bit_width-1:bit_width];
        Im_o        = rd_data[bit_width-1:0];
        overflow_o  = overflow_q;
    end

    fft_sample_ram #(
        .WIDTH(2 * bit_width),
        .DEPTH(N),
        .AW   (SIZE)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (wr_en),
        .waddr_i(wr_addr),
        .wdata_i({Re_i, Im_i}),
        .re_i   (rd_en),
        .raddr_i(rd_addr),
        .rdata_o(rd_data)
    );

endmodule
